wbm_cmd_initiator: RTL
======================

Name: wbm_cmd_initiator

Overview:
- Wishbone classic (B4, non-pipelined) master. It converts single-beat commands from a valid/ready command port into bus cycles toward a Wishbone slave, such as the user-area wbs_* target.
- Each cycle resolves to ack, err, or timeout. The result goes out on a valid/ready response port.
- Used as the on-chip initiator for bring-up and loopback of user-area slave logic. One outstanding transaction at a time.

Parameters:
- TIMEOUT_CYCLES, 255: bus-cycle abort limit in clocks. 0 disables the timeout.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Must be a multiple of 8. SEL width = DATA_W/8.

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_sel_i  in  DATA_W/8  byte selects
- cmd_adr_i  in  ADDR_W  byte address
- cmd_dat_i  in  DATA_W  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_dat_o  out  DATA_W  read data; 0 for writes, err and timeout
- rsp_status_o  out  2  00 OK, 01 ERR, 10 TIMEOUT
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls
- wbm_sel_o  out  DATA_W/8  byte selects
- wbm_adr_o  out  ADDR_W  address
- wbm_dat_o  out  DATA_W  write data
- wbm_ack_i, wbm_err_i  in  1  slave terminations
- wbm_dat_i  in  DATA_W  slave read data
- busy_o  out  1  state != IDLE

Behaviour:
- **Clocking/reset:** one clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- **Reset values:** every registered output is 0 (cyc, stb, we, sel, adr, dat, rsp_valid, rsp_dat, rsp_status). State = IDLE, timeout counter = 0.
- **cmd_ready_o:** combinational = (state == IDLE) & ~wb_rst_i, so it reads 1 from the first cycle after reset deasserts.
- **FSM states:** IDLE, BUS, RESP.
- **IDLE → BUS:** on cmd handshake at edge k, register we/sel/adr/dat onto the wbm_* outputs. cyc_o = stb_o = 1 from cycle k+1. Counter clears.
- **BUS, termination:** hold cyc/stb and all wbm_* outputs stable. At each edge, sample ack/err.
  - err = 1: status ERR. err has priority over a simultaneous ack.
  - else ack = 1: status OK; rsp_dat = wbm_dat_i if read, else 0.
  - else counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: status TIMEOUT, rsp_dat = 0.
  - else counter increments (saturating).
  - ack/err arriving on the same edge as expiry wins over TIMEOUT.
- **BUS → RESP:** on any termination at edge m, cyc/stb = 0 and rsp_valid = 1 in cycle m+1. we/sel/adr/dat return to 0.
- **RESP:** rsp_valid, rsp_dat and rsp_status are held stable until rsp_ready. On handshake go to IDLE; rsp_valid = 0 and cmd_ready = 1 next cycle.
- **Latency and throughput:**
  - Zero-wait-state slave: accept edge k → ack sampled at edge k+1 → rsp_valid in cycle k+2.
  - Maximum throughput is one transaction per 3 cycles when rsp_ready is held at 1.
- **Timeout length:** the bus cycle lasts exactly TIMEOUT_CYCLES clocks before abort.
- **Stray inputs:** ack/err outside BUS are ignored.
- **Reset mid-operation:** asserting wb_rst_i in any state drops cyc/stb at the next edge. Any pending response is discarded and no response is emitted for the aborted command.
- **Width rules:**
  - Counter width = clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Status is a 2-bit enum; 11 is reserved and never driven.

Decomposition:
- **Package wbm_pkg:**
  - status enum: WBM_OK = 2'b00, WBM_ERR = 2'b01, WBM_TIMEOUT = 2'b10
  - FSM state enum
  - WBM_SEL_W function of DATA_W
- **Sub-module wbm_timeout_cnt:** clear, enable, expired output, parameterised by TIMEOUT_CYCLES. Constant 0 means expired is never asserted.
- All other logic stays in wbm_cmd_initiator.

Test Plan:
- **Write, zero-wait slave:** cmd we = 1, adr = 0x3000_0004, dat = 0xDEAD_BEEF, sel = 0xF. Expected: cyc/stb high for exactly 1 cycle with those values, then rsp_valid 2 cycles after accept, status 00, rsp_dat = 0.
- **Read, slave acks after 3 wait states:** read with wbm_dat_i = 0x1234_5678 on the ack cycle. Expected: cyc high 4 cycles, rsp_dat = 0x1234_5678, status 00, wbm_* stable throughout.
- **Slave asserts err and ack together on 2nd bus cycle:** expected status 01, rsp_dat = 0, cyc drops next cycle.
- **Timeout, TIMEOUT_CYCLES = 16, silent slave:** expected cyc high exactly 16 cycles, status 10. Repeat with ack on the 16th cycle: expected status 00.
- **Response backpressure:** rsp_ready = 0 for 5 cycles. Expected: rsp held stable, cmd_ready = 0, a new cmd_valid is not accepted, and it is accepted in the cycle after the rsp handshake.
- **Reset mid-operation:** wb_rst_i for 1 cycle during BUS. Expected: all outputs 0 at next edge, no response emitted, cmd_ready = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/wbm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbm_pkg
// Description : Shared types and helpers for the Wishbone command initiator:
//               response status codes, FSM state encoding and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package wbm_pkg;

  // Response status; 2'b11 is reserved and never produced.
  typedef enum logic [1:0] {
    WBM_OK      = 2'b00,
    WBM_ERR     = 2'b01,
    WBM_TIMEOUT = 2'b10
  } wbm_status_e;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } wbm_state_e;

  // Byte-select width for a given data width.
  function automatic int WBM_SEL_W(input int data_w);
    return data_w / 8;
  endfunction

  // Timeout counter width: clog2(limit+1), never narrower than one bit.
  function automatic int wbm_cnt_w(input int timeout_cycles);
    if (timeout_cycles < 1) begin
      return 1;
    end
    return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbm_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wbm_timeout_cnt
// Description : Bus-cycle watchdog. Counts enabled clocks since the last clear
//               and flags the final allowed clock of a bus cycle. A limit of
//               zero removes the counter and never flags expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module wbm_timeout_cnt
  import wbm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = wbm_cnt_w(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout_en
      // Expiry is reported while the count sits on the last allowed clock,
      // so the bus cycle lasts exactly TIMEOUT_CYCLES clocks.
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Next count: clear wins, otherwise saturating increment when enabled.
      always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
          cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Count register with synchronous reset.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = (cnt_q == LIMIT);
    end else begin : g_timeout_dis
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wbm_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : wbm_cmd_initiator
// Description : Wishbone B4 classic single-beat master. Accepts one command
//               on a valid/ready port, runs one bus cycle, and returns the
//               outcome (ack / err / timeout) on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module wbm_cmd_initiator
  import wbm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  // Command port
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_we_i,
  input  logic [WBM_SEL_W(DATA_W)-1:0] cmd_sel_i,
  input  logic [ADDR_W-1:0]            cmd_adr_i,
  input  logic [DATA_W-1:0]            cmd_dat_i,
  // Response port
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_W-1:0]            rsp_dat_o,
  output logic [1:0]                   rsp_status_o,
  // Wishbone master
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic                         wbm_we_o,
  output logic [WBM_SEL_W(DATA_W)-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]            wbm_adr_o,
  output logic [DATA_W-1:0]            wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic [DATA_W-1:0]            wbm_dat_i,
  // Status
  output logic                         busy_o
);

  localparam int SEL_W = WBM_SEL_W(DATA_W);

  wbm_state_e        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  wbm_status_e       rsp_status_q, rsp_status_d;

  logic              cnt_clear;
  logic              cnt_en;
  logic              cnt_expired;
  logic              cmd_fire;

  // Watchdog for the active bus cycle.
  wbm_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .expired_o(cnt_expired)
  );

  // Ready is gated by reset so nothing is offered while the block is held.
  assign cmd_ready_o = (state_q == ST_IDLE) & ~wb_rst_i;
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;

  // Next-state and datapath: launch, terminate and hand back the response.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_d   = ST_BUS;
          cyc_d     = 1'b1;
          we_d      = cmd_we_i;
          sel_d     = cmd_sel_i;
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          cnt_clear = 1'b1;
        end
      end

      ST_BUS: begin
        // Slave terminations take precedence over the watchdog; err beats ack.
        if (wbm_err_i || wbm_ack_i || cnt_expired) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          adr_d       = '0;
          dat_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          if (wbm_err_i) begin
            rsp_status_d = WBM_ERR;
          end else if (wbm_ack_i) begin
            rsp_status_d = WBM_OK;
            if (!we_q) begin
              rsp_dat_d = wbm_dat_i;
            end
          end else begin
            rsp_status_d = WBM_TIMEOUT;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d      = ST_IDLE;
          rsp_valid_d  = 1'b0;
          rsp_dat_d    = '0;
          rsp_status_d = WBM_OK;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WBM_OK;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
